// File: rtl/phase_accum_engine.sv
// Time-multiplexed phase accumulator for the OPL3 operator datapath.
// Per-slot phase and period parity live in internal storage; each visit takes two cycles.
module phase_accum_engine #(
    parameter int NUM_SLOTS       = 36,
    parameter int SLOT_WIDTH      = 6,
    parameter int ACC_WIDTH       = 20,
    parameter int MOD_WIDTH       = 13,
    parameter int MOD_SHIFT       = 10,
    parameter int PHASE_OUT_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ready,
    input  logic                       in_valid,
    input  logic [SLOT_WIDTH-1:0]      in_slot,
    input  logic [ACC_WIDTH-1:0]       phase_inc,
    input  logic [1:0]                 mode,
    input  logic                       key_on_pulse,
    input  logic [MOD_WIDTH-1:0]       modulation,
    output logic                       out_valid,
    output logic [SLOT_WIDTH-1:0]      out_slot,
    output logic [PHASE_OUT_WIDTH-1:0] out_phase,
    output logic                       out_odd_period,
    output logic                       out_wrap,
    output logic                       dbg_state
);

    // Handshake: a slot is taken on a rising clk edge when in_valid=1, ready=1 and
    // in_slot < NUM_SLOTS; its result is presented with out_valid=1 exactly two edges later.

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT  = SLOT_WIDTH'(NUM_SLOTS - 1);
    localparam logic [SLOT_WIDTH:0]   SLOT_LIMIT = (SLOT_WIDTH + 1)'(NUM_SLOTS);

    state_t                  state;
    state_t                  state_next;
    logic [SLOT_WIDTH-1:0]   clr_cnt;
    logic                    clearing;
    logic                    accept;

    logic [ACC_WIDTH-1:0]    acc_mem [NUM_SLOTS];
    logic                    odd_mem [NUM_SLOTS];

    logic                    s1_valid;
    logic [SLOT_WIDTH-1:0]   s1_slot;
    logic [ACC_WIDTH-1:0]    s1_inc;
    logic [1:0]              s1_mode;
    logic                    s1_key;
    logic [MOD_WIDTH-1:0]    s1_mod;
    logic [ACC_WIDTH-1:0]    s1_acc;
    logic                    s1_odd;
    logic                    fwd;

    logic [ACC_WIDTH-1:0]    inc_eff;
    logic [ACC_WIDTH:0]      sum;
    logic [ACC_WIDTH-1:0]    mod_ext;
    logic [ACC_WIDTH-1:0]    wb_acc;
    logic                    wb_odd;
    logic                    wb_wrap;
    logic [ACC_WIDTH-1:0]    final_phase;

    // FSM: state register (the sweep counter advances alongside it)
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (clearing) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_cnt == LAST_SLOT) state_next = ST_RUN;
    end

    always_comb begin
        ready     = (state == ST_RUN);
        clearing  = (state == ST_CLEAR);
        dbg_state = state;
    end

    assign accept = in_valid && ready && ({1'b0, in_slot} < SLOT_LIMIT);
    // A same-slot visit one cycle behind must see the value S2 is writing right now.
    assign fwd    = s1_valid && (s1_slot == in_slot);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
        if (accept) begin
            s1_slot <= in_slot;
            s1_inc  <= phase_inc;
            s1_mode <= mode;
            s1_key  <= key_on_pulse;
            s1_mod  <= modulation;
            s1_acc  <= fwd ? wb_acc : acc_mem[in_slot];
            s1_odd  <= fwd ? wb_odd : odd_mem[in_slot];
        end
    end

    always_comb begin
        case (s1_mode)
            2'd1:    inc_eff = s1_inc << 1;
            2'd2:    inc_eff = '0;
            default: inc_eff = s1_inc;
        endcase
        sum     = {1'b0, s1_acc} + {1'b0, inc_eff};
        mod_ext = {{(ACC_WIDTH - MOD_WIDTH){s1_mod[MOD_WIDTH-1]}}, s1_mod} << MOD_SHIFT;
        if (s1_key) begin
            wb_acc      = '0;
            wb_odd      = 1'b0;
            wb_wrap     = 1'b0;
            final_phase = '0;
        end else begin
            wb_acc      = sum[ACC_WIDTH-1:0];
            wb_wrap     = sum[ACC_WIDTH];
            wb_odd      = s1_odd ^ sum[ACC_WIDTH];
            final_phase = wb_acc + mod_ext;
        end
    end

    // Clear sweep and S2 write-back never overlap: the pipeline is empty until ready rises.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clearing) begin
                acc_mem[clr_cnt] <= '0;
                odd_mem[clr_cnt] <= 1'b0;
            end else if (s1_valid) begin
                acc_mem[s1_slot] <= wb_acc;
                odd_mem[s1_slot] <= wb_odd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_slot       <= '0;
            out_phase      <= '0;
            out_odd_period <= 1'b0;
            out_wrap       <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_slot       <= s1_slot;
                out_phase      <= final_phase[ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
                out_odd_period <= wb_odd;
                out_wrap       <= wb_wrap;
            end
        end
    end

endmodule

// File: doc/phase_accum_engine.md
Name: phase_accum_engine

Overview:
- Time-multiplexed, parametrised phase accumulator engine for the OPL3 operator datapath.
- Holds per-slot phase and odd-period state for NUM_SLOTS operator slots in internal storage.
- Each slot visit applies the frequency-multiply mode, key-on restart and modulation, then emits the phase index and period parity.
- Feeds the log-sine/exp waveform stage.
- Unlike the previous generation, it has:
  - configurable slot count and widths;
  - a synchronous clear sweep;
  - a valid handshake;
  - same-slot read-after-write forwarding;
  - correct per-slot period tracking, driven only by that slot's own accumulator carry.

Parameters:
- NUM_SLOTS, 36, number of operator slots (2 banks x 18).
- SLOT_WIDTH, 6, slot index width; must satisfy 2**SLOT_WIDTH >= NUM_SLOTS.
- ACC_WIDTH, 20, phase accumulator width.
- MOD_WIDTH, 13, signed modulation input width.
- MOD_SHIFT, 10, left shift applied to modulation before it is added to phase.
- PHASE_OUT_WIDTH, 10, width of the emitted phase index (top bits of the final phase).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ready  out  1  high when the engine accepts slots (low during the clear sweep).
- in_valid  in  1  slot request this cycle; ignored while ready=0.
- in_slot  in  SLOT_WIDTH  slot index; values >= NUM_SLOTS are dropped (no output, no state change).
- phase_inc  in  ACC_WIDTH  per-sample phase increment.
- mode  in  2  0=x1, 1=x2 (double frequency), 2=hold (no advance), 3=x1.
- key_on_pulse  in  1  restart this slot.
- modulation  in  MOD_WIDTH  signed phase modulation.
- out_valid  out  1  output qualifier.
- out_slot  out  SLOT_WIDTH  slot of the current output.
- out_phase  out  PHASE_OUT_WIDTH  final_phase[ACC_WIDTH-1 -: PHASE_OUT_WIDTH].
- out_odd_period  out  1  slot parity after this update.
- out_wrap  out  1  accumulator wrapped on this update.

Behaviour:
- Reset (synchronous, active-high):
  - While reset=1: ready=0, out_valid=0, out_slot=0, out_phase=0, out_odd_period=0, out_wrap=0.
  - Clear sweep: on the first cycle after reset deasserts, zero acc and odd for slots 0..NUM_SLOTS-1, one slot per cycle.
  - ready rises the cycle after slot NUM_SLOTS-1 is cleared, i.e. NUM_SLOTS cycles after reset falls.
  - Reset asserted mid-sweep or mid-pipeline aborts everything in flight and restarts the sweep after deassert.
- FSM: CLEAR (sweep counter 0..NUM_SLOTS-1) -> RUN. Any reset -> CLEAR.
- Pipeline (2 stages, latency exactly 2 cycles from an accepted in_valid to out_valid; throughput 1 slot per cycle):
  - S1 reads acc[in_slot] and odd[in_slot] and registers the inputs.
  - S2 computes, writes back, and registers the outputs.
- Effective increment, from mode: 0/3 -> phase_inc; 1 -> phase_inc<<1 (truncated to ACC_WIDTH); 2 -> 0.
- Accumulate: {carry, acc_next} = acc + inc_eff, with ACC_WIDTH+1 bit sum.
  - carry=1 -> out_wrap=1 and odd toggles.
  - Otherwise odd is unchanged.
- Final phase = acc_next + (sign-extended modulation << MOD_SHIFT), modulo 2**ACC_WIDTH.
  - Modulation never enters the stored accumulator.
  - Modulation never affects carry/odd.
- key_on_pulse=1 (overrides mode):
  - acc := 0, odd := 0.
  - out_phase = 0 (modulation ignored), out_wrap=0, out_odd_period=0.
- Forwarding: if S1 reads a slot that S2 writes in the same cycle, S1 uses S2's new acc/odd; stored-array values must never be stale.
- When in_valid=0, the ready=0 case, or the invalid-slot case: out_valid=0 next-but-one cycle. Other output fields hold their previous values.
- Slot state is independent: no update to one slot alters another slot's acc or odd.

Test Plan:
- Clear sweep: reset 1 cycle, count cycles to ready=1 -> exactly 36. A subsequent read of slot 35 with inc=0 and mod=0 gives out_phase=0, odd=0.
- Basic accumulate: slot 3, inc=0x00400, mode 0, mod=0, visited 4 times. Expected out_phase sequence 1,2,3,4, and out_valid exactly 2 cycles after each in_valid.
- Wrap/parity: slot 5, inc=0x80000, mode 0, 4 visits.
  - out_wrap sequence 0,1,0,1.
  - out_odd_period sequence 0,1,1,0.
  - slot 6 odd stays 0 throughout.
- Double/hold/modulation, slot 7 with inc=0x00400:
  - mode 1 -> out_phase=2.
  - mode 2 -> out_phase=2.
  - mode 0, mod=-1 -> out_phase=2; accumulator=0x00C00.
- Back-to-back same slot: slot 9 with inc=0x00400 on 3 consecutive cycles -> out_phase 1,2,3 on consecutive cycles (forwarding).
- Key-on and mid-run reset:
  - Key-on to slot 9 -> out_phase=0, odd=0; next visit gives 1.
  - Reset asserted with 2 slots in flight -> no out_valid until after the new sweep completes.
  - All slots read back zero after that sweep.
